// File: rtl/zap_sync_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/filter.
package zap_sync_pkg;

   localparam int MIN_STAGES = 2;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/zap_sync_filter_channel.sv
// One channel: synchronizer chain, stability filter, and registered level/edge flops.
module zap_sync_filter_channel
   import zap_sync_pkg::*;
#(
   parameter int   STAGES        = 2,
   parameter int   FILTER_CYCLES = 4,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall,
   output logic o_change_next
);

   logic [STAGES-1:0] r_chain;
   logic              r_sync;
   logic              r_rise;
   logic              r_fall;
   logic              w_s;
   logic              w_sync_next;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_chain <= {STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign w_s = r_chain[STAGES-1];

   generate
      if (FILTER_CYCLES == 0) begin : g_nofilter
         assign w_sync_next = w_s;
      end else begin : g_filter
         localparam int CW = clog2_min1(FILTER_CYCLES + 1);
         localparam logic [CW-1:0] LP_LAST = CW'(FILTER_CYCLES - 1);

         logic [CW-1:0] r_cnt;
         logic [CW-1:0] w_cnt_next;

         // Any return of s to the held level drops all accumulated credit.
         always_comb begin
            w_sync_next = r_sync;
            w_cnt_next  = r_cnt;
            if (w_s == r_sync) begin
               w_cnt_next = '0;
            end else if (r_cnt == LP_LAST) begin
               w_sync_next = w_s;
               w_cnt_next  = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= w_sync_next;
         r_rise <= w_sync_next & ~r_sync;
         r_fall <= ~w_sync_next & r_sync;
      end
   end

   // Exported so the top can register its OR in the same cycle as the pulses.
   assign o_change_next = w_sync_next ^ r_sync;

   assign o_sync = r_sync;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/zap_sync_filter.sv
// Multi-channel synchronizer plus glitch filter with registered rise/fall pulses.
module zap_sync_filter
   import zap_sync_pkg::*;
#(
   parameter int               WIDTH         = 1,
   parameter int               STAGES        = 2,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_any_change
);

   logic [WIDTH-1:0] w_change;
   logic             r_any_change;

   generate
      if (STAGES < MIN_STAGES) begin : g_bad_stages
         $error("zap_sync_filter: STAGES must be at least 2");
      end

      for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
         zap_sync_filter_channel #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[ch])
         ) u_channel (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_async       (i_async[ch]),
            .o_sync        (o_sync[ch]),
            .o_rise        (o_rise[ch]),
            .o_fall        (o_fall[ch]),
            .o_change_next (w_change[ch])
         );
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_any_change <= 1'b0;
      end else begin
         r_any_change <= |w_change;
      end
   end

   assign o_any_change = r_any_change;

endmodule
